// File: rtl/imem_loader_pkg.sv
// Shared processor definitions: loader state encoding, instruction memory
// geometry and big-endian byte lane selection.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam int IMEM_BYTES  = 512;
    localparam int IMEM_ADDR_W = 9;

    // Lane 0 is the most significant byte (big-endian memory image).
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] lane;
        case (idx)
            2'd0:    lane = word[31:24];
            2'd1:    lane = word[23:16];
            2'd2:    lane = word[15:8];
            default: lane = word[7:0];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Serializes 32-bit program words into byte writes to instruction memory,
// holding the processor in reset while a load session is running.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES  = IMEM_BYTES,
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              word_valid,
    input  logic [31:0]       word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-2:0] word_count
);

    // One extra address bit so the pointer can reach MEM_BYTES without wrapping.
    localparam logic [ADDR_W:0]   ADDR_START = (ADDR_W+1)'(START_ADDR);
    localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W+1)'(MEM_BYTES - 4);
    localparam logic [ADDR_W:0]   ADDR_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-2:0] COUNT_ONE  = (ADDR_W-1)'(1);

    state_t            state_reg, state_next;
    logic [ADDR_W:0]   addr_reg, addr_next;
    logic [1:0]        byte_idx_reg, byte_idx_next;
    logic [31:0]       wbuf_reg, wbuf_next;
    logic              lbuf_reg, lbuf_next;
    logic [ADDR_W-2:0] word_count_reg, word_count_next;
    logic              room;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= ADDR_START;
            byte_idx_reg   <= 2'd0;
            wbuf_reg       <= 32'd0;
            lbuf_reg       <= 1'b0;
            word_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            byte_idx_reg   <= byte_idx_next;
            wbuf_reg       <= wbuf_next;
            lbuf_reg       <= lbuf_next;
            word_count_reg <= word_count_next;
        end
    end

    assign room = (addr_reg <= ADDR_LIMIT);

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        byte_idx_next   = byte_idx_reg;
        wbuf_next       = wbuf_reg;
        lbuf_next       = lbuf_reg;
        word_count_next = word_count_reg;

        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next      = ST_ACCEPT;
                    addr_next       = ADDR_START;
                    word_count_next = '0;
                end
            end
            ST_ACCEPT: begin
                if (!room) begin
                    state_next = ST_ERROR;
                end else if (word_valid) begin
                    wbuf_next     = word_data;
                    lbuf_next     = word_last;
                    byte_idx_next = 2'd0;
                    state_next    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_next     = addr_reg + ADDR_ONE;
                byte_idx_next = byte_idx_reg + 2'd1;
                if (byte_idx_reg == 2'd3) begin
                    word_count_next = word_count_reg + COUNT_ONE;
                    state_next      = lbuf_reg ? ST_DONE : ST_ACCEPT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // All outputs are decoded from registered state so reset removes them at once.
    assign word_ready = (state_reg == ST_ACCEPT) && room;
    assign mem_we     = (state_reg == ST_WRITE);
    assign mem_addr   = addr_reg[ADDR_W-1:0];
    assign mem_wdata  = byte_lane(wbuf_reg, byte_idx_reg);
    assign busy       = (state_reg == ST_ACCEPT) || (state_reg == ST_WRITE);
    assign done       = (state_reg == ST_DONE);
    assign overflow   = (state_reg == ST_ERROR);
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader with a byte-level write
// scoreboard fed by accepted words.
module tb_imem_loader;

    localparam int MEM   = 64;
    localparam int AW    = 6;
    localparam int START = 0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          word_valid = 1'b0;
    logic [31:0]   word_data = 32'd0;
    logic          word_last = 1'b0;
    logic          word_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW-2:0] word_count;

    imem_loader #(
        .MEM_BYTES (MEM),
        .ADDR_W    (AW),
        .START_ADDR(START)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .word_valid(word_valid),
        .word_data (word_data),
        .word_last (word_last),
        .word_ready(word_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: session address pointer, word tally, expected byte writes.
    typedef struct {
        int         a;
        logic [7:0] d;
    } wr_t;

    int  model_addr  = START;
    int  model_count = 0;
    wr_t exp_q[$];

    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            if (word_ready)
                chk("ready_room", 32'(model_addr <= MEM - 4), 32'd1);
            if (mem_we) begin
                chk("ready_in_write", 32'(word_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_we", 32'(mem_we), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e.a));
                    chk("wr_data", 32'(mem_wdata), 32'(e.d));
                    $display("write addr=%0d data=0x%02h", mem_addr, mem_wdata);
                end
            end
            if (word_valid && word_ready) begin
                for (int k = 0; k < 4; k++)
                    exp_q.push_back('{model_addr + k, 8'((word_data >> (24 - 8 * k)) & 32'hff)});
                model_addr += 4;
                model_count++;
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_addr  = START;
        model_count = 0;
        exp_q.delete();
    endtask

    // Returns one cycle after the accepting edge (first byte write cycle).
    task automatic send_word(input logic [31:0] d, input logic last, input bit hold);
        bit acc = 1'b0;
        word_valid = 1'b1;
        word_data  = d;
        word_last  = last;
        for (int n = 0; n < 60 && !acc; n++) begin
            @(negedge clk);
            if (word_ready) acc = 1'b1;
            @(posedge clk); #1;
        end
        chk("accept_timeout", 32'(acc), 32'd1);
        $display("word 0x%08h last=%0d accepted=%0d", d, last, acc);
        if (!hold) begin
            word_valid = 1'b0;
            word_last  = 1'b0;
        end
    endtask

    task automatic wait_end();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done || overflow) break;
        end
        chk("end_reached", 32'(done | overflow), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sw_bytes [4];
        int         nw;
        sw_bytes[0] = 8'h24; sw_bytes[1] = 8'h01; sw_bytes[2] = 8'h00; sw_bytes[3] = 8'h02;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(word_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'(START));
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);

        // Single word, exact cycle-by-cycle writes
        do_start();
        send_word(32'h24010002, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sw_we", 32'(mem_we), 32'd1);
            chk("sw_addr", 32'(mem_addr), 32'(START + i));
            chk("sw_data", 32'(mem_wdata), 32'(sw_bytes[i]));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("sw_done", 32'(done), 32'd1);
        chk("sw_busy", 32'(busy), 32'd0);
        chk("sw_count", 32'(word_count), 32'd1);
        @(posedge clk); #1;

        // Ten words with a 3-cycle gap between words 4 and 5
        do_start();
        for (int w = 0; w < 10; w++) begin
            if (w == 5) repeat (3) @(posedge clk);
            #0;
            send_word($urandom, w == 9, 1'b0);
        end
        wait_end();
        chk("mw_done", 32'(done), 32'd1);
        chk("mw_count", 32'(word_count), 32'd10);
        chk("mw_model_addr", 32'(model_addr), 32'd40);
        chk("mw_model_count", 32'(word_count), 32'(model_count));
        @(posedge clk); #1;

        // Overflow: 16 words fill the memory, the 17th is never accepted
        do_start();
        for (int w = 0; w < MEM / 4; w++) send_word($urandom, 1'b0, 1'b0);
        word_valid = 1'b1;
        word_data  = $urandom;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk("ovf_ready", 32'(word_ready), 32'd0);
            @(posedge clk); #1;
        end
        word_valid = 1'b0;
        @(negedge clk);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_done", 32'(done), 32'd0);
        chk("ovf_busy", 32'(busy), 32'd0);
        chk("ovf_count", 32'(word_count), 32'(MEM / 4));
        $display("overflow session: count=%0d overflow=%0d", word_count, overflow);
        @(posedge clk); #1;

        // Reset during the third byte of a word
        do_start();
        send_word(32'hDEADBEEF, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_discard", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(word_ready), 32'd0);
        chk("mid_rst_count", 32'(word_count), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'(START));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_start();
        send_word($urandom, 1'b1, 1'b0);
        wait_end();
        chk("post_rst_count", 32'(word_count), 32'd1);
        @(posedge clk); #1;

        // start while writing is ignored; start in DONE restarts the session
        do_start();
        send_word($urandom, 1'b0, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_word($urandom, 1'b1, 1'b0);
        wait_end();
        chk("rs_count", 32'(word_count), 32'd2);
        @(posedge clk); #1;
        do_start();
        @(negedge clk);
        chk("rs_done_clr", 32'(done), 32'd0);
        chk("rs_count_clr", 32'(word_count), 32'd0);
        chk("rs_addr", 32'(mem_addr), 32'(START));
        chk("rs_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        send_word($urandom, 1'b1, 1'b0);
        wait_end();
        @(posedge clk); #1;

        // Last word with word_valid held high afterwards
        do_start();
        send_word($urandom, 1'b1, 1'b1);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (n >= 4) chk("lw_ready", 32'(word_ready), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("lw_done", 32'(done), 32'd1);
        chk("lw_count", 32'(word_count), 32'd1);
        @(posedge clk); #1;
        word_valid = 1'b0;
        word_last  = 1'b0;

        // Random sessions with random idle gaps
        for (int s = 0; s < 6; s++) begin
            do_start();
            nw = int'($urandom_range(1, 8));
            for (int w = 0; w < nw; w++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send_word($urandom, w == nw - 1, 1'b0);
            end
            wait_end();
            chk("rnd_done", 32'(done), 32'd1);
            chk("rnd_ovf", 32'(overflow), 32'd0);
            chk("rnd_count", 32'(word_count), 32'(nw));
            chk("rnd_busy", 32'(busy), 32'd0);
            chk("rnd_drained", 32'(exp_q.size()), 32'd0);
            $display("session %0d: words=%0d count=%0d", s, nw, word_count);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
